pipe_hazard_ctrl: RTL

Pipeline control unit for the 8-bit pipelined core. It drives the enable, flush and bubble controls of the PC and the L1 (IF/ID), L2 (ID/EX) and L3 (EX/MEM) stage registers. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, with a timeout watchdog and a saturating stall counter. It sits beside the datapath, takes hazard inputs from the decode, execute and memory stages, and returns per-stage controls in the same cycle.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline control for the 8-bit core. It drives the PC, L1 (IF/ID), L2 (ID/EX)
// and L3 (EX/MEM) register controls from the decode, execute and memory hazard
// inputs. It handles load-use stalls, taken-branch squashes and data-memory waits,
// and provides a timeout watchdog and a saturating stall counter.
// Controls are combinational from the state and the current inputs, with zero latency.

module pipe_hazard_ctrl #(
   parameter int REG_AW      = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic              clk2,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_branch_taken,
   input  logic              mem_access,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic              pc_en,
   output logic              l1_en,
   output logic              l1_flush,
   output logic              l2_en,
   output logic              l2_bubble,
   output logic              l3_en,
   output logic              l3_bubble,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              timeout_err
);

   // The wait counter must be able to hold MEM_TIMEOUT-1.
   localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   state_t          state;
   logic [WW-1:0]   wait_cnt;

   logic load_use;
   logic mem_miss;
   logic wait_release;
   logic wait_last;

   // Hazard qualifiers. Register 0 is hard-wired, so it never causes a load-use hazard.
   always_comb begin
      load_use     = ex_memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
      mem_miss     = mem_access && !mem_ready;
      wait_release = mem_ready || !mem_access;
      wait_last    = (wait_cnt == WW'(MEM_TIMEOUT - 1));
   end

   // Per-stage controls, with the reset values forced while rst_n is low.
   always_comb begin
      // NOTE: every output gets a default first, so no path through this block leaves a value held; that is what keeps it free of latches.
      mem_req   = 1'b0;
      pc_en     = 1'b0;
      l1_en     = 1'b0;
      l1_flush  = 1'b0;
      l2_en     = 1'b0;
      l2_bubble = 1'b0;
      l3_en     = 1'b0;
      l3_bubble = 1'b0;

      if (!rst_n) begin
         l1_flush  = 1'b1;
         l2_bubble = 1'b1;
         l3_bubble = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               mem_req = mem_access;
               if (mem_miss) begin
                  // Freeze everything, including the memory-stage instruction itself.
               end else if (ex_branch_taken) begin
                  pc_en     = 1'b1;
                  l1_en     = 1'b1;
                  l1_flush  = 1'b1;
                  l2_en     = 1'b1;
                  l2_bubble = 1'b1;
                  l3_en     = 1'b1;
               end else if (load_use) begin
                  l2_en     = 1'b1;
                  l2_bubble = 1'b1;
                  l3_en     = 1'b1;
               end else begin
                  pc_en = 1'b1;
                  l1_en = 1'b1;
                  l2_en = 1'b1;
                  l3_en = 1'b1;
               end
            end
            MEM_WAIT: begin
               mem_req = mem_access;
               // On the release cycle, branch and load-use are not evaluated.
               if (wait_release) begin
                  pc_en = 1'b1;
                  l1_en = 1'b1;
                  l2_en = 1'b1;
                  l3_en = 1'b1;
               end
            end
            default: begin
               // ERR: the pipe stays frozen and memory is left alone until reset.
            end
         endcase
      end
   end

   // FSM, wait counter and sticky timeout flag.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register samples the pre-edge values of the others.
         unique case (state)
            RUN: begin
               if (mem_miss) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (wait_release) begin
                  state <= RUN;
               end else if (wait_last) begin
                  state       <= ERR;
                  timeout_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            default: begin
               state <= ERR;
            end
         endcase
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk2 or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!pc_en && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
